// File: rtl/cpu_ahb_pkg.sv
// Shared encodings for the CPU host-access AHB-Lite bridge.
package cpu_ahb_pkg;

  localparam logic [1:0] REG_IM   = 2'b00;
  localparam logic [1:0] REG_DM   = 2'b01;
  localparam logic [1:0] REG_RF   = 2'b10;
  localparam logic [1:0] REG_CTRL = 2'b11;

  localparam logic [13:0] OFF_CTRL  = 14'h0000;
  localparam logic [13:0] OFF_CYCLE = 14'h0004;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ERR1    = 2'd2,
    ST_ERR2    = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_ahb_ctrl_regs.sv
// Run bit, CPU reset flop, execution-cycle counter and CTRL/CYCLE read mux.
module cpu_ahb_ctrl_regs
  import cpu_ahb_pkg::*;
#(
  parameter logic [15:0] VERSION = 16'h006A
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_wr_en,
  input  logic [31:0] i_wdata,
  input  logic        i_rd_cycle,
  output logic [31:0] o_rdata,
  output logic        o_run,
  output logic        o_cpu_rstn
);

  logic        r_run;
  logic        r_cpu_rstn;
  logic [31:0] r_cycle;
  logic        w_run_rise;
  logic        w_unused;

  assign w_run_rise = i_wr_en & i_wdata[0] & ~r_run;
  assign w_unused   = ^i_wdata[31:1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run      <= 1'b0;
      r_cpu_rstn <= 1'b0;
      r_cycle    <= '0;
    end else begin
      if (i_wr_en) r_run <= i_wdata[0];
      r_cpu_rstn <= r_run;
      // Counts cycles the core is out of reset; a fresh start clears it.
      if (w_run_rise)      r_cycle <= '0;
      else if (r_cpu_rstn) r_cycle <= r_cycle + 32'd1;
    end
  end

  assign o_rdata    = i_rd_cycle ? r_cycle : {VERSION, 15'b0, r_run};
  assign o_run      = r_run;
  assign o_cpu_rstn = r_cpu_rstn;

endmodule

// File: rtl/cpu_ahb_bridge.sv
// AHB-Lite slave giving the system bus access to CPU IM/DM/RF and the run/cycle control block.
//   state      | meaning
//   ST_IDLE    | ready; completes zero-wait data phases and the last cycle of IM/DM reads
//   ST_RD_WAIT | single wait state while the synchronous IM/DM read resolves
//   ST_ERR1    | first ERROR cycle (HREADYOUT low)
//   ST_ERR2    | second ERROR cycle (HREADYOUT high)
module cpu_ahb_bridge
  import cpu_ahb_pkg::*;
#(
  parameter int          MEM_AW  = 11,
  parameter logic [15:0] VERSION = 16'h006A
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              cpu_rstn,
  output logic [4:0]        ahb_rf_addr,
  input  logic [31:0]       ahb_rf_data,
  output logic [MEM_AW-1:0] ahb_im_addr,
  output logic [31:0]       ahb_im_din,
  output logic              ahb_im_wen,
  input  logic [31:0]       ahb_im_dout,
  output logic [MEM_AW-1:0] ahb_dm_addr,
  output logic [31:0]       ahb_dm_din,
  output logic              ahb_dm_wen,
  input  logic [31:0]       ahb_dm_dout
);

  state_e            r_state, w_state_nxt;
  logic              r_wr_mem, r_wr_ctrl, r_rd_zw, r_rd_mem, r_ctrl_off;
  logic [1:0]        r_region;
  logic [MEM_AW-1:0] r_im_addr, r_dm_addr;
  logic [4:0]        r_rf_addr;
  logic [31:0]       r_hold, w_ctrl_rdata;
  logic [1:0]        w_region;
  logic              w_accept, w_ok, w_err, w_is_mem, w_is_ctrl, w_run, w_ctrl_bad;
  logic              w_unused;

  assign w_region  = HADDR[15:14];
  assign w_is_mem  = (w_region == REG_IM) | (w_region == REG_DM);
  assign w_is_ctrl = (w_region == REG_CTRL);
  // ERR2 already drives HREADYOUT high, so the next address phase can land there.
  assign w_accept  = HSEL & HTRANS[1] & HREADY & ((r_state == ST_IDLE) | (r_state == ST_ERR2));
  assign w_ctrl_bad = (HADDR[13:0] != OFF_CTRL) & (HADDR[13:0] != OFF_CYCLE);
  assign w_err = (HSIZE != HSIZE_WORD) | (HADDR[1:0] != 2'b00)
               | (w_is_mem & HADDR[13]) | (w_is_mem & HWRITE & w_run)
               | ((w_region == REG_RF) & HWRITE)
               | (w_is_ctrl & (w_ctrl_bad | (HWRITE & (HADDR[13:0] == OFF_CYCLE))));
  assign w_ok     = w_accept & ~w_err;
  assign w_unused = ^{HADDR[31:16], HTRANS[0]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_err)                 w_state_nxt = ST_ERR1;
          else if (w_is_mem & ~HWRITE) w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: w_state_nxt = ST_IDLE;
      ST_ERR1:    w_state_nxt = ST_ERR2;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_wr_mem   <= 1'b0;
      r_wr_ctrl  <= 1'b0;
      r_rd_zw    <= 1'b0;
      r_rd_mem   <= 1'b0;
      r_ctrl_off <= 1'b0;
      r_region   <= REG_IM;
      r_im_addr  <= '0;
      r_dm_addr  <= '0;
      r_rf_addr  <= '0;
      r_hold     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_mem  <= w_ok & w_is_mem & HWRITE;
      r_wr_ctrl <= w_ok & w_is_ctrl & HWRITE;
      r_rd_zw   <= w_ok & ~w_is_mem & ~HWRITE;
      r_rd_mem  <= (r_state == ST_RD_WAIT);
      if (w_accept) begin
        r_region   <= w_region;
        r_ctrl_off <= HADDR[2];
      end
      if (w_ok & (w_region == REG_IM)) r_im_addr <= HADDR[MEM_AW+1:2];
      if (w_ok & (w_region == REG_DM)) r_dm_addr <= HADDR[MEM_AW+1:2];
      if (w_ok & (w_region == REG_RF)) r_rf_addr <= HADDR[6:2];
      if (r_rd_mem | r_rd_zw)          r_hold    <= HRDATA;
    end
  end

  always_comb begin
    HRDATA = r_hold;
    if (r_rd_mem)     HRDATA = (r_region == REG_IM) ? ahb_im_dout : ahb_dm_dout;
    else if (r_rd_zw) HRDATA = (r_region == REG_RF) ? ahb_rf_data : w_ctrl_rdata;
  end

  assign HREADYOUT   = ~((r_state == ST_RD_WAIT) | (r_state == ST_ERR1));
  assign HRESP       = ((r_state == ST_ERR1) | (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign ahb_im_addr = r_im_addr;
  assign ahb_dm_addr = r_dm_addr;
  assign ahb_rf_addr = r_rf_addr;
  assign ahb_im_din  = HWDATA;
  assign ahb_dm_din  = HWDATA;
  assign ahb_im_wen  = r_wr_mem & (r_region == REG_IM);
  assign ahb_dm_wen  = r_wr_mem & (r_region == REG_DM);

  cpu_ahb_ctrl_regs #(.VERSION(VERSION)) u_ctrl_regs (
    .clk       (clk),
    .rstn      (rstn),
    .i_wr_en   (r_wr_ctrl),
    .i_wdata   (HWDATA),
    .i_rd_cycle(r_ctrl_off),
    .o_rdata   (w_ctrl_rdata),
    .o_run     (w_run),
    .o_cpu_rstn(cpu_rstn)
  );

endmodule

// File: tb/tb_cpu_ahb_bridge.sv
// Bench for cpu_ahb_bridge: bus tasks, IM/DM/RF memory models and a reference memory/cycle model.
module tb_cpu_ahb_bridge;

  localparam int MEM_AW = 11;

  logic              clk = 1'b0;
  logic              rstn;
  logic              HSEL, HWRITE, HREADY, HREADYOUT, HRESP, cpu_rstn;
  logic [31:0]       HADDR, HWDATA, HRDATA;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [4:0]        ahb_rf_addr;
  logic [31:0]       ahb_rf_data, ahb_im_din, ahb_im_dout, ahb_dm_din, ahb_dm_dout;
  logic [MEM_AW-1:0] ahb_im_addr, ahb_dm_addr;
  logic              ahb_im_wen, ahb_dm_wen;

  logic [31:0] im_mem [0:2047] = '{default: '0};
  logic [31:0] dm_mem [0:2047] = '{default: '0};
  logic [31:0] rf_regs [0:31];
  logic [31:0] ref_im [0:31];
  logic [31:0] ref_dm [0:31];

  int checks = 0;
  int failures = 0;
  int im_wen_cnt = 0, dm_wen_cnt = 0;
  int im_last_addr = 0, dm_last_addr = 0;
  logic [31:0] im_last_din = '0, dm_last_din = '0;
  int cyc_model = 0;
  logic prev_cpu = 1'b0;

  logic [31:0] s_rdata;
  logic        s_resp1, s_resp2, s_ok, s_cpu;
  logic [4:0]  s_rf_addr;
  int          s_waits;

  always #5 clk = ~clk;
  assign HREADY = HREADYOUT;
  assign ahb_rf_data = rf_regs[ahb_rf_addr];

  cpu_ahb_bridge #(.MEM_AW(MEM_AW), .VERSION(16'h006A)) dut (
    .clk(clk), .rstn(rstn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .cpu_rstn(cpu_rstn), .ahb_rf_addr(ahb_rf_addr), .ahb_rf_data(ahb_rf_data),
    .ahb_im_addr(ahb_im_addr), .ahb_im_din(ahb_im_din), .ahb_im_wen(ahb_im_wen),
    .ahb_im_dout(ahb_im_dout), .ahb_dm_addr(ahb_dm_addr), .ahb_dm_din(ahb_dm_din),
    .ahb_dm_wen(ahb_dm_wen), .ahb_dm_dout(ahb_dm_dout)
  );

  // Synchronous-read memories sitting on the host ports
  always @(posedge clk) begin
    if (ahb_im_wen) im_mem[ahb_im_addr] <= ahb_im_din;
    if (ahb_dm_wen) dm_mem[ahb_dm_addr] <= ahb_dm_din;
    ahb_im_dout <= im_mem[ahb_im_addr];
    ahb_dm_dout <= dm_mem[ahb_dm_addr];
  end

  // Write-pulse monitor and reference cycle count: cycles spent with cpu_rstn high since it last rose
  always @(negedge clk) begin
    if (ahb_im_wen) begin im_wen_cnt++; im_last_addr = int'(ahb_im_addr); im_last_din = ahb_im_din; end
    if (ahb_dm_wen) begin dm_wen_cnt++; dm_last_addr = int'(ahb_dm_addr); dm_last_din = ahb_dm_din; end
    if (cpu_rstn) cyc_model = prev_cpu ? cyc_model + 1 : 1;
    prev_cpu = cpu_rstn;
  end

  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata);
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    s_ok = 1'b0; s_waits = 0; s_resp1 = 1'b0; s_resp2 = 1'b0; s_rdata = '0;
    for (int k = 0; k < 8 && !s_ok; k++) begin
      @(negedge clk);
      if (k == 0) begin s_resp1 = HRESP; s_rf_addr = ahb_rf_addr; s_cpu = cpu_rstn; end
      if (HREADYOUT) begin s_ok = 1'b1; s_rdata = HRDATA; s_resp2 = HRESP; end
      else s_waits++;
    end
    #1;
    checks++;
    if (!s_ok) begin failures++; $display("FAIL bus_timeout addr=%h got no HREADYOUT within 8 cycles", addr); end
  endtask

  task automatic test_reset();
    rstn = 1'b0; HSEL = 0; HTRANS = 0; HADDR = 0; HWRITE = 0; HSIZE = 3'b010; HWDATA = 0;
    repeat (3) @(negedge clk);
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin failures++; $display("FAIL rst_hs ready=%b resp=%b exp 1/0", HREADYOUT, HRESP); end
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
    checks++; if (cpu_rstn !== 1'b0 || ahb_im_wen !== 1'b0 || ahb_dm_wen !== 1'b0) begin failures++; $display("FAIL rst_ctl cpu_rstn=%b imwen=%b dmwen=%b exp 0", cpu_rstn, ahb_im_wen, ahb_dm_wen); end
    checks++; if (ahb_im_addr !== '0 || ahb_dm_addr !== '0 || ahb_rf_addr !== '0) begin failures++; $display("FAIL rst_addr im=%h dm=%h rf=%h exp 0", ahb_im_addr, ahb_dm_addr, ahb_rf_addr); end
    @(posedge clk); #1 rstn = 1'b1;
    bus_xfer(1'b0, 32'h0000_C000, 3'b010, 32'h0);
    checks++; if (s_rdata !== 32'h006A_0000) begin failures++; $display("FAIL rst_ctrl_read got=%h exp=006a0000", s_rdata); end
    checks++; if (s_waits !== 0 || s_resp2 !== 1'b0 || s_cpu !== 1'b0) begin failures++; $display("FAIL rst_ctrl_hs waits=%0d resp=%b cpu=%b exp 0/0/0", s_waits, s_resp2, s_cpu); end
  endtask

  task automatic test_im_rw();
    int pre;
    pre = im_wen_cnt;
    bus_xfer(1'b1, 32'h0000_0008, 3'b010, 32'h2008_0005);
    ref_im[2] = 32'h2008_0005;
    checks++; if (im_wen_cnt !== pre + 1 || im_last_addr !== 2 || im_last_din !== 32'h2008_0005) begin failures++; $display("FAIL im_write pulses=%0d addr=%0d din=%h exp 1/2/20080005", im_wen_cnt - pre, im_last_addr, im_last_din); end
    checks++; if (s_waits !== 0 || s_resp2 !== 1'b0) begin failures++; $display("FAIL im_write_hs waits=%0d resp=%b exp 0/0", s_waits, s_resp2); end
    bus_xfer(1'b0, 32'h0000_0008, 3'b010, 32'h0);
    checks++; if (s_rdata !== ref_im[2] || s_waits !== 1) begin failures++; $display("FAIL im_read data=%h waits=%0d exp %h/1", s_rdata, s_waits, ref_im[2]); end
    repeat (3) @(negedge clk);
    checks++; if (HRDATA !== ref_im[2] || ahb_im_wen !== 1'b0) begin failures++; $display("FAIL idle_hold hrdata=%h wen=%b exp %h/0", HRDATA, ahb_im_wen, ref_im[2]); end
  endtask

  task automatic test_run_cycle();
    logic [31:0] first;
    bus_xfer(1'b1, 32'h0000_C000, 3'b010, 32'h1);
    checks++; if (s_cpu !== 1'b0) begin failures++; $display("FAIL run_early cpu_rstn=%b exp 0 in write data phase", s_cpu); end
    @(posedge clk); @(negedge clk);
    checks++; if (cpu_rstn !== 1'b0) begin failures++; $display("FAIL run_delay cpu_rstn=%b exp 0 right after write", cpu_rstn); end
    @(negedge clk);
    checks++; if (cpu_rstn !== 1'b1) begin failures++; $display("FAIL run_rise cpu_rstn=%b exp 1", cpu_rstn); end
    bus_xfer(1'b0, 32'h0000_C000, 3'b010, 32'h0);
    checks++; if (s_rdata !== 32'h006A_0001) begin failures++; $display("FAIL ctrl_run_read got=%h exp=006a0001", s_rdata); end
    repeat (10) @(posedge clk);
    bus_xfer(1'b1, 32'h0000_C000, 3'b010, 32'h0);
    repeat (4) @(posedge clk);
    bus_xfer(1'b0, 32'h0000_C004, 3'b010, 32'h0);
    first = s_rdata;
    checks++; if (first !== 32'(cyc_model) || s_waits !== 0) begin failures++; $display("FAIL cycle_count got=%0d waits=%0d exp %0d/0", first, s_waits, cyc_model); end
    repeat (5) @(posedge clk);
    bus_xfer(1'b0, 32'h0000_C004, 3'b010, 32'h0);
    checks++; if (s_rdata !== first || cpu_rstn !== 1'b0) begin failures++; $display("FAIL cycle_hold got=%0d cpu=%b exp %0d/0", s_rdata, cpu_rstn, first); end
  endtask

  task automatic test_errors();
    int pim, pdm;
    logic [31:0] addrs [6];
    logic        wrs [6];
    logic [2:0]  sizes [6];
    logic [31:0] run_v [6];
    addrs = '{32'h4000, 32'h0010, 32'h0004, 32'h8004, 32'hC004, 32'hC008};
    wrs   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sizes = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b010};
    run_v = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      bus_xfer(1'b1, 32'h0000_C000, 3'b010, run_v[i]);
      pim = im_wen_cnt; pdm = dm_wen_cnt;
      bus_xfer(wrs[i], addrs[i], sizes[i], 32'hCAFE_0000);
      checks++; if (s_resp1 !== 1'b1 || s_resp2 !== 1'b1 || s_waits !== 1) begin failures++; $display("FAIL err_resp case=%0d resp1=%b resp2=%b waits=%0d exp 1/1/1", i, s_resp1, s_resp2, s_waits); end
      checks++; if (im_wen_cnt !== pim || dm_wen_cnt !== pdm) begin failures++; $display("FAIL err_side_effect case=%0d im_pulses=%0d dm_pulses=%0d exp 0", i, im_wen_cnt - pim, dm_wen_cnt - pdm); end
    end
    bus_xfer(1'b1, 32'h0000_C000, 3'b010, 32'h0);
    bus_xfer(1'b0, 32'h0000_8014, 3'b010, 32'h0);
    checks++; if (s_rf_addr !== 5'd5 || s_rdata !== rf_regs[5] || s_waits !== 0) begin failures++; $display("FAIL rf_read idx=%0d data=%h waits=%0d exp 5/%h/0", s_rf_addr, s_rdata, s_waits, rf_regs[5]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    v = $urandom;
    @(posedge clk); #1;
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h400C; HSIZE = 3'b010;
    @(posedge clk); #1;
    HWDATA = v; HWRITE = 0;
    @(negedge clk);
    checks++; if (ahb_dm_wen !== 1'b1 || ahb_dm_addr !== 11'd3 || ahb_dm_din !== v || HREADYOUT !== 1'b1) begin failures++; $display("FAIL b2b_write wen=%b addr=%0d din=%h ready=%b exp 1/3/%h/1", ahb_dm_wen, ahb_dm_addr, ahb_dm_din, HREADYOUT, v); end
    @(posedge clk); #1;
    HSEL = 0; HTRANS = 2'b00;
    @(negedge clk);
    checks++; if (HREADYOUT !== 1'b0 || ahb_dm_wen !== 1'b0) begin failures++; $display("FAIL b2b_wait ready=%b wen=%b exp 0/0", HREADYOUT, ahb_dm_wen); end
    @(negedge clk);
    ref_dm[3] = v;
    checks++; if (HREADYOUT !== 1'b1 || HRDATA !== ref_dm[3]) begin failures++; $display("FAIL b2b_read ready=%b data=%h exp 1/%h", HREADYOUT, HRDATA, ref_dm[3]); end
  endtask

  task automatic test_random_mem();
    int sel, w, kind, pim, pdm;
    logic wr, err;
    logic [31:0] addr, data;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 1); w = $urandom_range(0, 31); kind = $urandom_range(0, 5);
      data = $urandom;
      addr = {16'h0, (sel == 1) ? 2'b01 : 2'b00, 14'(w * 4)};
      wr = (kind < 2) ? 1'b1 : (kind < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      err = (kind >= 4);
      if (kind == 4) addr = addr + 32'($urandom_range(1, 3));
      if (kind == 5) addr = addr | 32'h2000;
      pim = im_wen_cnt; pdm = dm_wen_cnt;
      bus_xfer(wr, addr, 3'b010, data);
      if (err) begin
        checks++; if (s_resp1 !== 1'b1 || s_resp2 !== 1'b1 || im_wen_cnt !== pim || dm_wen_cnt !== pdm) begin failures++; $display("FAIL rnd_err addr=%h resp=%b%b pulses=%0d exp 11/0", addr, s_resp1, s_resp2, im_wen_cnt - pim + dm_wen_cnt - pdm); end
      end else if (wr) begin
        if (sel == 1) ref_dm[w] = data; else ref_im[w] = data;
        checks++;
        if ((sel == 1) ? (dm_wen_cnt !== pdm + 1 || im_wen_cnt !== pim || dm_last_addr !== w || dm_last_din !== data)
                       : (im_wen_cnt !== pim + 1 || dm_wen_cnt !== pdm || im_last_addr !== w || im_last_din !== data)
            || s_waits !== 0 || s_resp2 !== 1'b0) begin
          failures++; $display("FAIL rnd_write addr=%h im_pulses=%0d dm_pulses=%0d waits=%0d exp one pulse on region %0d word %0d", addr, im_wen_cnt - pim, dm_wen_cnt - pdm, s_waits, sel, w);
        end
      end else begin
        checks++;
        if (s_rdata !== ((sel == 1) ? ref_dm[w] : ref_im[w]) || s_waits !== 1 || s_resp2 !== 1'b0) begin
          failures++; $display("FAIL rnd_read addr=%h got=%h waits=%0d exp %h/1", addr, s_rdata, s_waits, (sel == 1) ? ref_dm[w] : ref_im[w]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int pim;
    bus_xfer(1'b1, 32'h0000_C000, 3'b010, 32'h1);
    repeat (3) @(posedge clk);
    pim = im_wen_cnt;
    @(posedge clk); #1;
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h0008; HSIZE = 3'b010;
    @(posedge clk); #1;
    HSEL = 0; HTRANS = 2'b00;
    checks++; if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL abort_inwait ready=%b exp 0", HREADYOUT); end
    rstn = 1'b0;
    #1;
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || cpu_rstn !== 1'b0) begin failures++; $display("FAIL abort_reset ready=%b resp=%b cpu=%b exp 1/0/0", HREADYOUT, HRESP, cpu_rstn); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bus_xfer(1'b0, 32'h0000_C000, 3'b010, 32'h0);
    checks++; if (s_rdata !== 32'h006A_0000 || im_wen_cnt !== pim) begin failures++; $display("FAIL abort_run got=%h pulses=%0d exp 006a0000/0", s_rdata, im_wen_cnt - pim); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_regs[i] = $urandom;
      ref_im[i] = '0;
      ref_dm[i] = '0;
    end
    test_reset();
    test_im_rw();
    test_run_cycle();
    test_errors();
    test_back_to_back();
    test_random_mem();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_ahb_bridge.md
Name: cpu_ahb_bridge

Overview:
AHB-Lite slave that sits directly upstream of the CPU top level and drives its host-access ports: instruction-memory load, data-memory access, and register-file peek. It also owns a control/status register block that gates CPU reset (run bit) and counts execution cycles. The system bus loads a program, releases the CPU, then reads results back through this block.

Parameters:
MEM_AW, 11, word-address width of IM/DM host ports
VERSION, 16'h006A, value returned in CTRL[31:16]

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  byte address
HTRANS  in  2  transfer type; NONSEQ/SEQ (bit1=1) = valid
HWRITE  in  1  1=write
HSIZE  in  3  transfer size; only 3'b010 legal
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready (address phase accept)
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
cpu_rstn  out  1  reset to CPU core, active-low
ahb_rf_addr  out  5  RF read index
ahb_rf_data  in  32  RF read data (combinational)
ahb_im_addr  out  MEM_AW  IM word address
ahb_im_din  out  32  IM write data
ahb_im_wen  out  1  IM write enable
ahb_im_dout  in  32  IM read data (1-cycle synchronous)
ahb_dm_addr / ahb_dm_din / ahb_dm_wen / ahb_dm_dout  same as IM, for DM

Behaviour:
- Clocking/reset: one clock `clk`; `rstn` is asynchronous, active-low.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, run=0, cpu_rstn=0, cycle_cnt=0, all *_wen=0, all *_addr=0.
- Reset mid-transfer aborts the transfer; no write is issued.
- Address-phase accept: HSEL & HTRANS[1] & HREADY at a rising edge. Latch addr, region, write flag and error flag.
- Address map, region = HADDR[15:14]:
  - 00 = IM, word address HADDR[12:2].
  - 01 = DM, word address HADDR[12:2].
  - 10 = RF, read-only, index HADDR[6:2].
  - 11 = CTRL: offset 0x0 = CTRL {VERSION, 15'b0, run}; offset 0x4 = CYCLE, read-only.
- Error conditions:
  - HSIZE != 010
  - HADDR[1:0] != 0
  - IM/DM with HADDR[13] = 1
  - Any write to RF or CYCLE
  - IM/DM write while run = 1
  - CTRL offset other than 0x0 or 0x4
- Error response: the access has no side effect. Two-cycle ERROR: cycle 1 HRESP=1, HREADYOUT=0; cycle 2 HRESP=1, HREADYOUT=1; then IDLE.
- FSM states: IDLE, RD_WAIT, ERR1, ERR2.
  - IDLE: data phases that need no wait are completed here.
  - IDLE -> RD_WAIT on an accepted IM/DM read.
  - IDLE -> ERR1 on an accepted erroneous transfer.
  - RD_WAIT -> IDLE after one cycle.
  - ERR1 -> ERR2 -> IDLE.
- IM/DM read (accepted at edge T):
  - Cycle T..T+1: the *_addr register is updated at edge T; HREADYOUT=0.
  - Cycle T+1..T+2: HRDATA = *_dout; HREADYOUT=1.
  - Exactly one wait state.
- IM/DM write: during the data-phase cycle after accept, *_wen=1 for exactly one cycle, *_addr = latched address, *_din = HWDATA (passthrough). Zero wait. A read immediately following a write to the same address returns the new data.
- RF/CTRL/CYCLE read: zero wait. HRDATA valid in the data-phase cycle; ahb_rf_addr is registered at accept.
- CTRL write: run <= HWDATA[0] at the end of the data phase.
- cpu_rstn is a flop: cpu_rstn <= run, so it follows run one cycle later.
- CYCLE counter:
  - Increments every clock while cpu_rstn=1.
  - Cleared to 0 on a run 0->1 transition.
  - Holds its value when run=0.
  - Wraps 0xFFFFFFFF -> 0.
- Pipelining:
  - A new address phase may be accepted in a zero-wait data phase (back-to-back).
  - While HREADYOUT=0, HREADY is low and no new transfer is accepted.
- Idle bus: *_addr hold their last value; *_wen=0; HRDATA holds its last value.
- IDLE/BUSY HTRANS or HSEL=0: no action, OKAY.

Decomposition:
- Shared package cpu_ahb_pkg:
  - region encodings (REG_IM, REG_DM, REG_RF, REG_CTRL)
  - CTRL/CYCLE offsets
  - HTRANS/HSIZE/HRESP constants
  - FSM state typedef
- One natural sub-module: cpu_ahb_ctrl_regs, holding the run bit, the cpu_rstn flop, the CYCLE counter and CTRL read mux.

Test Plan:
- Reset, then read CTRL at 0xC000 -> HRDATA=0x006A0000, cpu_rstn=0, zero wait, OKAY.
- Write IM 0x0008=0x20080005, then read 0x0008 -> ahb_im_wen pulses 1 cycle with ahb_im_addr=2; read returns 0x20080005 after one wait state.
- Write CTRL=1, run 10 cycles, write CTRL=0, read 0xC004 -> cpu_rstn rises 1 cycle after the write; CYCLE=10 (±1 per defined edge), held after stop.
- With run=1, write DM 0x4000 -> ERROR two-cycle response, ahb_dm_wen stays 0. With run=0, HSIZE=byte -> ERROR.
- Write 0xCAFE0000 to RF region 0x8004 -> ERROR. Read 0x8014 -> ahb_rf_addr=5, HRDATA=ahb_rf_data, zero wait.
- Assert rstn low during RD_WAIT -> HREADYOUT=1, HRESP=0, run=0 immediately. Back-to-back DM write/read to address 3 returns the written value.
